// File: rtl/regbank_pkg.sv
// Shared constants, types and helpers for the multi-port register bank.
package regbank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // Upper bound on write ports that the priority helper can arbitrate.
    localparam int MAX_WR = 16;

    // Address width for a given depth. This is never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [DEF_DATA_W-1:0]        data_t;
    typedef logic [$clog2(DEF_DEPTH)-1:0] addr_t;

    // Index of the highest-numbered hitting port. The last writer wins.
    function automatic int win_port(input logic [MAX_WR-1:0] hits);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (hits[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regbank_wr_arb.sv
// Write-port arbiter: tells whether any enabled write targets the query
// address and returns the data of the highest-priority matching port.
module regbank_wr_arb
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = addr_width(DEF_DEPTH),
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        write,
    input  logic [NUM_WR*AW-1:0]     dr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            query,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    logic [MAX_WR-1:0] hits;
    int                win;

    // Per-port match of enabled writes against the query address.
    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            hits[i] = write[i] && (dr[i*AW +: AW] == query);
        end
    end

    assign win  = win_port(hits);
    assign hit  = |hits;
    assign data = wr_data[win*DATA_W +: DATA_W];

endmodule

// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank with a per-register busy scoreboard,
// an optional hardwired zero register and optional same-cycle write bypass.
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        write,
    input  logic [NUM_WR*AW-1:0]     dr,
    input  logic [NUM_WR*DATA_W-1:0] wrData,
    input  logic                     rsv,
    input  logic [AW-1:0]            rsv_addr,
    input  logic [NUM_RD*AW-1:0]     sr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    output logic                     busy_any
);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0][DATA_W-1:0] reg_wdata;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_next;
    logic [DEPTH-1:0]             reg_hit;
    logic [DEPTH-1:0]             reg_we;
    logic [DEPTH-1:0]             reg_rsv;

    // Write decode. Each register gets its own arbiter. Register 0 is
    // excluded from writes and reserves when it is hardwired to zero.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        regbank_wr_arb #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_wr_dec (
            .write   (write),
            .dr      (dr),
            .wr_data (wrData),
            .query   (AW'(r)),
            .hit     (reg_hit[r]),
            .data    (reg_wdata[r])
        );

        assign reg_we[r]  = reg_hit[r] && !(ZERO_REG != 0 && r == 0);
        assign reg_rsv[r] = rsv && (rsv_addr == AW'(r)) && !(ZERO_REG != 0 && r == 0);
    end

    // A reserve outranks a retiring write to the same register. This covers
    // a new producer that issues while the old one writes back.
    assign busy_next = reg_rsv | (busy & ~reg_hit);

    // Storage and scoreboard. Everything clears on reset, and enables
    // seen while reset is held are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            busy <= busy_next;
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_we[r]) begin
                    regs[r] <= reg_wdata[r];
                end
            end
        end
    end

    assign busy_any = |busy;

    // Combinational read ports with optional forwarding of this cycle's writes.
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              byp_hit;
        logic [DATA_W-1:0] byp_data;
        logic [DATA_W-1:0] rd_val;
        logic              rd_busy;

        assign addr = sr[j*AW +: AW];

        regbank_wr_arb #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_byp (
            .write   (write),
            .dr      (dr),
            .wr_data (wrData),
            .query   (addr),
            .hit     (byp_hit),
            .data    (byp_data)
        );

        // Select the stored value, the forwarded write, or a hardwired zero.
        // A same-cycle reserve is never forwarded.
        always_comb begin
            rd_val  = regs[addr];
            rd_busy = busy[addr];
            if (BYPASS != 0 && reset && byp_hit) begin
                rd_val = byp_data;
                if (!(rsv && rsv_addr == addr)) begin
                    rd_busy = 1'b0;
                end
            end
            if (ZERO_REG != 0 && addr == '0) begin
                rd_val  = '0;
                rd_busy = 1'b0;
            end
        end

        assign rdData[j*DATA_W +: DATA_W] = rd_val;
        assign rdBusy[j]                  = rd_busy;
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp. Two copies of the bank run side by side,
// one with bypass and one without, and both are driven by the same stimulus.
module tb_regbank_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NV = 18;

    logic          clk;
    logic          reset;
    logic [1:0]    write;
    logic [2*AW-1:0] dr;
    logic [2*DW-1:0] wrData;
    logic          rsv;
    logic [AW-1:0] rsv_addr;
    logic [2*AW-1:0] sr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          busy_any;
    logic [2*DW-1:0] rd_data_nb;
    logic [1:0]    rd_busy_nb;
    logic          busy_any_nb;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]    wr;
        logic [AW-1:0] d0;
        logic [AW-1:0] d1;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        logic          rs;
        logic [AW-1:0] ra;
        logic [AW-1:0] s0;
        logic [AW-1:0] s1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic          e_rb0;
        logic          e_rb1;
        logic          e_any;
        logic [DW-1:0] e_nb0;
    } vec_t;

    vec_t vecs [NV];

    regbank_mp #(.BYPASS(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .dr       (dr),
        .wrData   (wrData),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .sr       (sr),
        .rdData   (rd_data),
        .rdBusy   (rd_busy),
        .busy_any (busy_any)
    );

    regbank_mp #(.BYPASS(0)) dut_nb (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .dr       (dr),
        .wrData   (wrData),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .sr       (sr),
        .rdData   (rd_data_nb),
        .rdBusy   (rd_busy_nb),
        .busy_any (busy_any_nb)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int wr, input int d0, input int d1,
                                input int w0, input int w1, input int rs,
                                input int ra, input int s0, input int s1,
                                input int erd0, input int erd1, input int erb0,
                                input int erb1, input int eany, input int enb0);
        vec_t v;
        v.wr    = 2'(wr);
        v.d0    = AW'(d0);
        v.d1    = AW'(d1);
        v.w0    = DW'(w0);
        v.w1    = DW'(w1);
        v.rs    = 1'(rs);
        v.ra    = AW'(ra);
        v.s0    = AW'(s0);
        v.s1    = AW'(s1);
        v.e_rd0 = DW'(erd0);
        v.e_rd1 = DW'(erd1);
        v.e_rb0 = 1'(erb0);
        v.e_rb1 = 1'(erb1);
        v.e_any = 1'(eany);
        v.e_nb0 = DW'(enb0);
        return v;
    endfunction

    task automatic apply_stimulus(input int wr, input int d0, input int d1,
                                  input int w0, input int w1, input int rs,
                                  input int ra, input int s0, input int s1);
        write    = 2'(wr);
        dr       = {AW'(d1), AW'(d0)};
        wrData   = {DW'(w1), DW'(w0)};
        rsv      = 1'(rs);
        rsv_addr = AW'(ra);
        sr       = {AW'(s1), AW'(s0)};
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Table: the register file holds reg[k]=10*k when this table starts.
        vecs[0]  = mk(3, 5, 5, 'h11, 'h22, 0, 0, 5, 6, 'h22, 60, 0, 0, 0, 50);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 'h22, 'h22, 0, 0, 0, 'h22);
        vecs[2]  = mk(1, 7, 0, 'hABCD, 0, 0, 0, 7, 8, 'hABCD, 80, 0, 0, 0, 70);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 7, 3, 'hABCD, 30, 0, 0, 0, 'hABCD);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 3, 3, 4, 30, 40, 0, 0, 0, 30);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 2, 30, 20, 1, 0, 1, 30);
        vecs[6]  = mk(1, 3, 0, 'h99, 0, 0, 0, 3, 3, 'h99, 'h99, 0, 0, 1, 30);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 3, 'h99, 'h99, 0, 0, 0, 'h99);
        vecs[8]  = mk(2, 0, 4, 0, 'h44, 1, 4, 4, 4, 'h44, 'h44, 0, 0, 0, 40);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 'h44, 0, 1, 0, 1, 'h44);
        vecs[10] = mk(1, 0, 0, 'hFFFF, 0, 1, 0, 0, 4, 0, 'h44, 0, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 'h44, 0, 1, 1, 0);
        vecs[12] = mk(1, 4, 0, 'h45, 0, 0, 0, 0, 4, 0, 'h45, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 'h45, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 6, 6, 6, 60, 60, 0, 0, 0, 60);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 6, 6, 6, 60, 60, 1, 1, 1, 60);
        vecs[16] = mk(2, 0, 6, 0, 'h66, 0, 0, 6, 6, 'h66, 'h66, 0, 0, 1, 60);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 6, 6, 'h66, 'h66, 0, 0, 0, 'h66);

        // Reset is held with an active write. Nothing may leak to the outputs.
        reset = 1'b0;
        apply_stimulus(1, 5, 0, 'h1234, 0, 1, 5, 5, 31);
        #1;
        check_output("rst_rd0", rd_data[31:0], 0);
        check_output("rst_rd1", rd_data[63:32], 0);
        check_output("rst_rb0", 32'(rd_busy[0]), 0);
        check_output("rst_any", 32'(busy_any), 0);
        @(posedge clk);
        #1;
        check_output("rst_edge_rd0", rd_data[31:0], 0);
        check_output("rst_edge_nb0", rd_data_nb[31:0], 0);
        check_output("rst_edge_any", 32'(busy_any), 0);

        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 5);
        #1;
        check_output("post_rst_rd0", rd_data[31:0], 0);

        // Fill every register with 10*k through port 0.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            apply_stimulus(1, k, 0, 10 * k, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 32; k += 2) begin
            @(negedge clk);
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, k, k + 1);
            #1;
            check_output($sformatf("fill_rd%0d", k), rd_data[31:0], (k == 0) ? 0 : 10 * k);
            check_output($sformatf("fill_rd%0d", k + 1), rd_data[63:32], 10 * (k + 1));
        end

        // Conflict, bypass, scoreboard and zero-register sequences.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply_stimulus(int'(vecs[i].wr), int'(vecs[i].d0), int'(vecs[i].d1),
                           int'(vecs[i].w0), int'(vecs[i].w1), int'(vecs[i].rs),
                           int'(vecs[i].ra), int'(vecs[i].s0), int'(vecs[i].s1));
            #1;
            check_output($sformatf("v%0d_rd0", i), rd_data[31:0], vecs[i].e_rd0);
            check_output($sformatf("v%0d_rd1", i), rd_data[63:32], vecs[i].e_rd1);
            check_output($sformatf("v%0d_rb0", i), 32'(rd_busy[0]), 32'(vecs[i].e_rb0));
            check_output($sformatf("v%0d_rb1", i), 32'(rd_busy[1]), 32'(vecs[i].e_rb1));
            check_output($sformatf("v%0d_any", i), 32'(busy_any), 32'(vecs[i].e_any));
            check_output($sformatf("v%0d_nb0", i), rd_data_nb[31:0], vecs[i].e_nb0);
        end

        // Reset mid-operation: reg 9 is reserved and written, then reset is
        // asserted between edges.
        @(negedge clk);
        apply_stimulus(1, 9, 0, 'h55, 0, 1, 9, 9, 9);
        #1;
        check_output("mid_byp_rd0", rd_data[31:0], 'h55);
        @(negedge clk);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
        #1;
        check_output("mid_rd0", rd_data[31:0], 'h55);
        check_output("mid_rb0", 32'(rd_busy[0]), 1);
        check_output("mid_any", 32'(busy_any), 1);
        #1;
        reset = 1'b0;
        #1;
        check_output("async_rd0", rd_data[31:0], 0);
        check_output("async_rb0", 32'(rd_busy[0]), 0);
        check_output("async_any", 32'(busy_any), 0);
        check_output("async_nb0", rd_data_nb[31:0], 0);
        apply_stimulus(1, 9, 0, 'h77, 0, 1, 9, 9, 9);
        #1;
        check_output("rst_wr_rd0", rd_data[31:0], 0);
        @(posedge clk);
        #1;
        check_output("rst_hold_rd0", rd_data[31:0], 0);
        check_output("rst_hold_any", 32'(busy_any), 0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
        #1;
        check_output("rel_rd0", rd_data[31:0], 0);
        check_output("rel_rb0", 32'(rd_busy[0]), 0);
        @(negedge clk);
        #1;
        check_output("rel2_rd0", rd_data[31:0], 0);
        check_output("rel2_nb0", rd_data_nb[31:0], 0);
        check_output("rel2_any", 32'(busy_any), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
Parametrised multi-port register bank with a per-register busy scoreboard. It succeeds the fixed 32x32 two-read/one-write bank and generalises data width, depth and read/write port counts. It adds an optional hardwired zero register, same-cycle write-to-read bypass, and busy/reserve tracking for the pipeline issue stage. It sits between decode (source/destination selects) and writeback (result writes).

Parameters:
DATA_W, 32, width of each register and data port
DEPTH, 32, number of registers (power of two, >=2)
NUM_RD, 2, number of combinational read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reserves
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  rising-edge clock, single domain
reset  in  1  asynchronous, active-low; low = reset asserted
write  in  NUM_WR  per-port write enable
dr  in  NUM_WR*AW  per-port write (destination) address
wrData  in  NUM_WR*DATA_W  per-port write data
rsv  in  1  reserve enable (mark register busy)
rsv_addr  in  AW  register to reserve
sr  in  NUM_RD*AW  per-port read (source) address
rdData  out  NUM_RD*DATA_W  per-port read data
rdBusy  out  NUM_RD  per-port busy flag of the addressed register
busy_any  out  1  OR of all busy bits

Behaviour:
- Reset (reset low, async): all registers = 0, all busy bits = 0. Outputs follow immediately via the combinational read path: rdData = 0, rdBusy = 0, busy_any = 0. Deassertion is synchronous to clk; the first write takes effect on the first rising edge after reset goes high.
- Reset while writes or reserves are in flight: all state cleared; enables sampled during reset are dropped.
- Write: on a rising edge, reg[dr[i]] <= wrData[i] for each i with write[i]=1.
- Same-address writes in one cycle: the highest-index port wins. With NUM_WR=2, port 1 overrides port 0.
- Read path, zero latency, combinational:
  - rdData[j] = reg[sr[j]].
  - With BYPASS=1 and a write to sr[j] this cycle, rdData[j] = that write's wrData, using the same port priority.
  - BYPASS=0: new data is visible the cycle after the edge.
- Zero register (ZERO_REG=1):
  - writes and reserves to address 0 are ignored.
  - rdData for address 0 is always 0, including under bypass.
  - rdBusy for address 0 is always 0.
- Scoreboard:
  - Edge with rsv=1 sets busy[rsv_addr].
  - Edge with any write[i] to address a clears busy[a].
  - Writes to a non-busy register are allowed and leave busy at 0.
- Simultaneous reserve and write to the same address: the reserve wins, busy stays 1. This models a new producer issued as the old one retires; the data is still written.
- Reserving an already-busy register: it stays busy. There is no error flag.
- rdBusy[j]:
  - equals busy[sr[j]];
  - with BYPASS=1, it is 0 if a write targets sr[j] this cycle and no reserve targets the same address.
  - Same-cycle reserve is never forwarded; it is visible next cycle.
- busy_any: registered view; the OR of the busy bits after the current edge.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Decomposition:
- Package regbank_pkg:
  - default DATA_W/DEPTH constants;
  - function clog2-based AW helper;
  - typedef for the address and data types;
  - function for priority selection of the winning write port.
- One sub-module, regbank_wr_arb: given write/dr/wrData and a query address, returns hit and the winning data.
  - Instanced once per read port for bypass.
  - Instanced once per register for the write decode.
- Scoreboard and storage stay in the top module.

Test Plan:
- Reset and fill: hold reset low, check all rdData=0. Release, write reg[k]=10*k for k=0..31 on port 0, then read pairs (k, k+1). Expect reg[0]=0 (ZERO_REG=1) and reg[k]=10*k otherwise.
- Write conflict: same cycle, port0 writes 5 -> 0x11, port1 writes 5 -> 0x22. Next cycle reg[5]=0x22.
- Bypass: write reg[7]=0xABCD while sr[0]=7. rdData[0]=0xABCD in the same cycle. Rerun with BYPASS=0: old value in the same cycle, 0xABCD the next cycle.
- Scoreboard: reserve 3, then rdBusy=1 and busy_any=1. Write 3 -> 0x99, then rdBusy=0 and busy_any=0. Reserve and write 4 in the same cycle: busy stays 1 and reg[4] holds the new data.
- Zero register: write 0xFFFF to 0 and reserve 0. Expect rdData=0, rdBusy=0, busy_any=0.
- Reset mid-operation: reserve 9 and write reg[9]=0x55, assert reset asynchronously between edges. Outputs go to 0 immediately, busy_any=0, and reg[9] reads 0 after release.
